cpu_traffic_initiator: RTL and testbench



---
 rtl/cpu_traffic_initiator.sv | 208 ++++++++++++++++++++
 tb/tb_cpu_traffic_initiator.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_traffic_initiator.sv
// CPU-port transaction initiator: queues requests, issues one command at a time, sources write
// bursts and sinks read bursts. Define CPU_INIT_CHECK_EN to build the read-data/stray-beat checker.
module cpu_traffic_initiator #(
    parameter int unsigned ADDR_W     = 27,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned BURST_LEN  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic              i_cpu_ck,
    input  logic              i_cpu_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_wr,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              o_cpu_valid,
    input  logic              i_cpu_ready,
    output logic              o_cpu_wr,
    output logic [ADDR_W-1:0] o_cpu_addr,
    output logic              o_cpu_wvalid,
    output logic [DATA_W-1:0] o_cpu_wdata,
    input  logic              i_cpu_wready,
    input  logic              i_cpu_rvalid,
    input  logic [DATA_W-1:0] i_cpu_rdata,
    output logic              o_busy,
    output logic [15:0]       o_done_cnt,
    output logic [15:0]       o_err_cnt,
    output logic              o_timeout
);
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BEAT_W = $clog2(BURST_LEN);
    localparam int unsigned TMR_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StCmd, StWdata, StRdata} state_e;

    state_e            r_state;
    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic              r_fifo_wr   [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic [BEAT_W-1:0] r_beat;
    logic [TMR_W-1:0]  r_timer;

    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_fifo_nempty_nxt;
    logic [BEAT_W-1:0] w_beat_inc;
    logic              w_last;
    logic              w_progress;
    logic              w_abort;
    logic [15:0]       w_done_sat;

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] addr,
                                              input logic [BEAT_W-1:0] beat);
        logic [DATA_W-1:0] p;
        p             = '0;
        p[8 +: ADDR_W] = addr;
        p[7:0]        = 8'(beat);
        return p;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign o_req_ready       = (r_count != CNT_W'(FIFO_DEPTH));
    assign w_push            = i_req_valid && o_req_ready;
    assign w_pop             = (r_state == StIdle) && (r_count != '0);
    assign w_count_nxt       = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_fifo_nempty_nxt = (w_count_nxt != '0);
    assign w_beat_inc        = r_beat + BEAT_W'(1);
    assign w_last            = (r_beat == BEAT_W'(BURST_LEN - 1));
    assign w_done_sat        = (o_done_cnt == 16'hFFFF) ? o_done_cnt : o_done_cnt + 16'd1;

    always_comb begin
        w_progress = 1'b0;
        unique case (r_state)
            StCmd:   w_progress = i_cpu_ready;
            StWdata: w_progress = i_cpu_wready;
            StRdata: w_progress = i_cpu_rvalid;
            default: w_progress = 1'b0;
        endcase
    end

    // Abort fires on the stall cycle that would take the timer past TIMEOUT-1.
    assign w_abort = (r_state != StIdle) && !w_progress && (r_timer == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge i_cpu_ck or negedge i_cpu_rst_n) begin
        if (!i_cpu_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= ptr_inc(r_rptr);
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge i_cpu_ck) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= i_req_addr;
            r_fifo_wr[r_wptr]   <= i_req_wr;
        end
    end

    always_ff @(posedge i_cpu_ck or negedge i_cpu_rst_n) begin
        if (!i_cpu_rst_n) begin
            r_state      <= StIdle;
            r_beat       <= '0;
            r_timer      <= '0;
            o_cpu_valid  <= 1'b0;
            o_cpu_wr     <= 1'b0;
            o_cpu_addr   <= '0;
            o_cpu_wvalid <= 1'b0;
            o_cpu_wdata  <= '0;
            o_busy       <= 1'b0;
            o_done_cnt   <= '0;
            o_timeout    <= 1'b0;
        end else begin
            o_busy <= 1'b1;
            if (r_state != StIdle) begin
                r_timer <= w_progress ? '0 : r_timer + TMR_W'(1);
            end
            unique case (r_state)
                StIdle: begin
                    if (w_pop) begin
                        o_cpu_valid <= 1'b1;
                        o_cpu_wr    <= r_fifo_wr[r_rptr];
                        o_cpu_addr  <= r_fifo_addr[r_rptr];
                        r_beat      <= '0;
                        r_timer     <= '0;
                        r_state     <= StCmd;
                    end else begin
                        o_busy <= w_fifo_nempty_nxt;
                    end
                end
                StCmd: begin
                    if (i_cpu_ready) begin
                        o_cpu_valid <= 1'b0;
                        if (o_cpu_wr) begin
                            o_cpu_wvalid <= 1'b1;
                            o_cpu_wdata  <= pat(o_cpu_addr, '0);
                            r_state      <= StWdata;
                        end else begin
                            r_state <= StRdata;
                        end
                    end
                end
                StWdata: begin
                    if (i_cpu_wready) begin
                        r_beat      <= w_beat_inc;
                        o_cpu_wdata <= pat(o_cpu_addr, w_beat_inc);
                        if (w_last) begin
                            o_cpu_wvalid <= 1'b0;
                            o_done_cnt   <= w_done_sat;
                            o_busy       <= w_fifo_nempty_nxt;
                            r_state      <= StIdle;
                        end
                    end
                end
                StRdata: begin
                    if (i_cpu_rvalid) begin
                        r_beat <= w_beat_inc;
                        if (w_last) begin
                            o_done_cnt <= w_done_sat;
                            o_busy     <= w_fifo_nempty_nxt;
                            r_state    <= StIdle;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
            if (w_abort) begin
                o_cpu_valid  <= 1'b0;
                o_cpu_wvalid <= 1'b0;
                o_timeout    <= 1'b1;
                o_busy       <= w_fifo_nempty_nxt;
                r_state      <= StIdle;
            end
        end
    end

`ifdef CPU_INIT_CHECK_EN
    logic w_err;

    // Any beat outside a read burst is stray; inside one it must match the address pattern.
    assign w_err = i_cpu_rvalid &&
                   ((r_state != StRdata) || (i_cpu_rdata != pat(o_cpu_addr, r_beat)));

    always_ff @(posedge i_cpu_ck or negedge i_cpu_rst_n) begin
        if (!i_cpu_rst_n) begin
            o_err_cnt <= '0;
        end else if (w_err && (o_err_cnt != 16'hFFFF)) begin
            o_err_cnt <= o_err_cnt + 16'd1;
        end
    end
`else
    logic w_unused_rdata;

    assign w_unused_rdata = ^i_cpu_rdata;
    assign o_err_cnt      = '0;
`endif

endmodule

// File: tb/tb_cpu_traffic_initiator.sv
// Bench for cpu_traffic_initiator: directed vector table, hand-written corner sequences and a
// randomized run scored against a transaction-level queue model.
module tb_cpu_traffic_initiator;
    localparam int unsigned ADDR_W     = 27;
    localparam int unsigned DATA_W     = 64;
    localparam int unsigned BURST_LEN  = 8;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned TIMEOUT    = 1024;
`ifdef CPU_INIT_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_req_wr;
    logic [ADDR_W-1:0] i_req_addr;
    logic              o_cpu_valid;
    logic              i_cpu_ready;
    logic              o_cpu_wr;
    logic [ADDR_W-1:0] o_cpu_addr;
    logic              o_cpu_wvalid;
    logic [DATA_W-1:0] o_cpu_wdata;
    logic              i_cpu_wready;
    logic              i_cpu_rvalid;
    logic [DATA_W-1:0] i_cpu_rdata;
    logic              o_busy;
    logic [15:0]       o_done_cnt;
    logic [15:0]       o_err_cnt;
    logic              o_timeout;

    cpu_traffic_initiator #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .BURST_LEN  (BURST_LEN),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .i_cpu_ck     (clk),
        .i_cpu_rst_n  (rst_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_wr     (i_req_wr),
        .i_req_addr   (i_req_addr),
        .o_cpu_valid  (o_cpu_valid),
        .i_cpu_ready  (i_cpu_ready),
        .o_cpu_wr     (o_cpu_wr),
        .o_cpu_addr   (o_cpu_addr),
        .o_cpu_wvalid (o_cpu_wvalid),
        .o_cpu_wdata  (o_cpu_wdata),
        .i_cpu_wready (i_cpu_wready),
        .i_cpu_rvalid (i_cpu_rvalid),
        .i_cpu_rdata  (i_cpu_rdata),
        .o_busy       (o_busy),
        .o_done_cnt   (o_done_cnt),
        .o_err_cnt    (o_err_cnt),
        .o_timeout    (o_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [26:0] addr;
        int          bad;
        logic [63:0] beat3;
        int          done;
        int          err;
    } vec_t;

    typedef struct packed {
        logic        wr;
        logic [26:0] addr;
    } req_t;

    int   errors = 0;
    int   checks = 0;
    vec_t vt[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pat(input logic [26:0] a, input int k);
        return (64'(a) << 8) + 64'(k);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req_valid  = 1'b0;
        i_req_wr     = 1'b0;
        i_req_addr   = '0;
        i_cpu_ready  = 1'b0;
        i_cpu_wready = 1'b0;
        i_cpu_rvalid = 1'b0;
        i_cpu_rdata  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic feed_read(input logic [26:0] addr, input int bad, input logic [63:0] b3);
        for (int k = 0; k < int'(BURST_LEN); k++) begin
            i_cpu_rvalid = 1'b1;
            i_cpu_rdata  = (k == 3) ? b3 : pat(addr, k);
            if (k == bad) i_cpu_rdata = i_cpu_rdata ^ 64'hDEAD;
            tick();
        end
        i_cpu_rvalid = 1'b0;
        tick();
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        i_req_valid  = 1'b1;
        i_req_wr     = v.wr;
        i_req_addr   = v.addr;
        i_cpu_ready  = 1'b1;
        i_cpu_wready = 1'b1;
        tick();
        i_req_valid = 1'b0;
        check("cmd_latency_n", 64'(o_cpu_valid), 64'd0);
        tick();
        check("cmd_latency_n1", 64'(o_cpu_valid), 64'd1);
        check("cmd_addr", 64'(o_cpu_addr), 64'(v.addr));
        check("cmd_wr", 64'(o_cpu_wr), 64'(v.wr));
        tick();
        check("cmd_drop", 64'(o_cpu_valid), 64'd0);
        if (v.wr) begin
            n = 0;
            for (int c = 0; c < int'(BURST_LEN) + 4; c++) begin
                if (o_cpu_wvalid) begin
                    check("wdata", o_cpu_wdata, pat(v.addr, n));
                    if (n == 3) check("wdata_beat3", o_cpu_wdata, v.beat3);
                    n++;
                end
                tick();
            end
            check("wvalid_cycles", 64'(n), 64'(BURST_LEN));
        end else begin
            feed_read(v.addr, v.bad, v.beat3);
        end
        check("vec_done_cnt", 64'(o_done_cnt), 64'(v.done));
        check("vec_err_cnt", 64'(o_err_cnt), 64'(v.err));
        check("vec_busy", 64'(o_busy), 64'd0);
    endtask

    task automatic test_backpressure();
        int  acc;
        int  ncmd;
        logic was_ready;
        do_reset();
        i_req_wr = 1'b1;
        acc = 0;
        for (int c = 0; c < 20 && acc < 5; c++) begin
            i_req_valid = 1'b1;
            i_req_addr  = 27'h200 + 27'(acc);
            was_ready   = o_req_ready;
            tick();
            if (was_ready) begin
                acc++;
                if (acc == 4) check("bp_ready_after_4", 64'(o_req_ready), 64'd1);
            end
        end
        i_req_valid = 1'b0;
        check("bp_accepted", 64'(acc), 64'd5);
        check("bp_ready_full", 64'(o_req_ready), 64'd0);
        check("bp_cmd_held", 64'(o_cpu_addr), 64'h200);
        i_cpu_ready  = 1'b1;
        i_cpu_wready = 1'b1;
        ncmd = 0;
        for (int c = 0; c < 200 && o_done_cnt != 16'd5; c++) begin
            if (o_cpu_valid) begin
                check("bp_cmd_order", 64'(o_cpu_addr), 64'h200 + 64'(ncmd));
                ncmd++;
            end
            tick();
        end
        check("bp_done", 64'(o_done_cnt), 64'd5);
        tick();
        check("bp_busy", 64'(o_busy), 64'd0);
        check("bp_ready_back", 64'(o_req_ready), 64'd1);
    endtask

    task automatic test_timeout_then_reset();
        do_reset();
        i_cpu_ready  = 1'b1;
        i_cpu_wready = 1'b0;
        i_req_valid  = 1'b1;
        i_req_wr     = 1'b1;
        i_req_addr   = 27'h300;
        tick();
        i_req_wr   = 1'b0;
        i_req_addr = 27'h340;
        tick();
        i_req_valid = 1'b0;
        for (int c = 0; c < 10 && !o_cpu_wvalid; c++) tick();
        check("tmo_wvalid_start", 64'(o_cpu_wvalid), 64'd1);
        repeat (TIMEOUT - 1) tick();
        check("tmo_not_yet", 64'(o_timeout), 64'd0);
        check("tmo_wvalid_held", 64'(o_cpu_wvalid), 64'd1);
        tick();
        check("tmo_flag", 64'(o_timeout), 64'd1);
        check("tmo_wvalid_drop", 64'(o_cpu_wvalid), 64'd0);
        check("tmo_done_unchanged", 64'(o_done_cnt), 64'd0);
        check("tmo_busy_queued", 64'(o_busy), 64'd1);
        tick();
        check("tmo_next_valid", 64'(o_cpu_valid), 64'd1);
        check("tmo_next_addr", 64'(o_cpu_addr), 64'h340);
        check("tmo_next_wr", 64'(o_cpu_wr), 64'd0);
        tick();
        feed_read(27'h340, -1, pat(27'h340, 3));
        check("tmo_next_done", 64'(o_done_cnt), 64'd1);
        check("tmo_sticky", 64'(o_timeout), 64'd1);

        // Read in flight plus one queued write, then reset lands during beat 4.
        i_req_valid = 1'b1;
        i_req_wr    = 1'b0;
        i_req_addr  = 27'h400;
        tick();
        i_req_wr   = 1'b1;
        i_req_addr = 27'h480;
        tick();
        i_req_valid = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            i_cpu_rvalid = 1'b1;
            i_cpu_rdata  = pat(27'h400, k);
            tick();
        end
        i_cpu_rdata = pat(27'h400, 4);
        rst_n       = 1'b0;
        #1;
        check("rst_valid", 64'(o_cpu_valid), 64'd0);
        check("rst_wvalid", 64'(o_cpu_wvalid), 64'd0);
        check("rst_addr", 64'(o_cpu_addr), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_done", 64'(o_done_cnt), 64'd0);
        check("rst_timeout", 64'(o_timeout), 64'd0);
        check("rst_err", 64'(o_err_cnt), 64'd0);
        check("rst_ready", 64'(o_req_ready), 64'd1);
        i_cpu_rvalid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_ready", 64'(o_req_ready), 64'd1);
        check("post_rst_busy", 64'(o_busy), 64'd0);
        check("post_rst_no_cmd", 64'(o_cpu_valid), 64'd0);
    endtask

    task automatic test_stray();
        do_reset();
        i_cpu_rvalid = 1'b1;
        i_cpu_rdata  = {$urandom, $urandom};
        tick();
        i_cpu_rvalid = 1'b0;
        tick();
        check("stray_err", 64'(o_err_cnt), 64'(CHK));
        check("stray_busy", 64'(o_busy), 64'd0);
        check("stray_valid", 64'(o_cpu_valid), 64'd0);
        check("stray_done", 64'(o_done_cnt), 64'd0);
    endtask

    task automatic test_random();
        req_t q[$];
        req_t cur;
        int   mphase;
        int   k;
        int   exp_done;
        int   exp_err;
        logic corrupt;
        logic drain;
        do_reset();
        mphase   = 0;
        k        = 0;
        exp_done = 0;
        exp_err  = 0;
        cur      = '0;
        drain    = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (c >= 1500) drain = 1'b1;
            if (drain && q.size() == 0 && mphase == 0) break;
            i_req_valid  = !drain && ($urandom % 3 == 0);
            i_req_wr     = ($urandom % 2 == 0);
            i_req_addr   = 27'($urandom);
            i_cpu_ready  = drain || ($urandom % 2 == 0);
            i_cpu_wready = drain || ($urandom % 4 != 0);
            if (mphase == 2) i_cpu_rvalid = drain || ($urandom % 3 != 0);
            else             i_cpu_rvalid = !drain && ($urandom % 50 == 0);
            corrupt     = i_cpu_rvalid && !drain && ($urandom % 8 == 0);
            i_cpu_rdata = pat(cur.addr, k);
            if (corrupt) i_cpu_rdata = i_cpu_rdata ^ (64'h1 << $urandom_range(63, 0));

            check("rnd_wvalid_phase", 64'(o_cpu_wvalid), 64'(mphase == 1));
            if (i_req_valid && o_req_ready) q.push_back('{wr: i_req_wr, addr: i_req_addr});
            if (i_cpu_rvalid) begin
                if (mphase == 2) begin
                    if (corrupt) exp_err += CHK;
                    k++;
                    if (k == int'(BURST_LEN)) begin
                        exp_done++;
                        mphase = 0;
                    end
                end else begin
                    exp_err += CHK;
                end
            end
            if (mphase == 1 && o_cpu_wvalid && i_cpu_wready) begin
                check("rnd_wdata", o_cpu_wdata, pat(cur.addr, k));
                k++;
                if (k == int'(BURST_LEN)) begin
                    exp_done++;
                    mphase = 0;
                end
            end
            if (o_cpu_valid && i_cpu_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_cmd_unexpected: got addr %0h expected no command",
                             o_cpu_addr);
                end else begin
                    cur    = q.pop_front();
                    mphase = cur.wr ? 1 : 2;
                    k      = 0;
                    check("rnd_cmd_addr", 64'(o_cpu_addr), 64'(cur.addr));
                    check("rnd_cmd_wr", 64'(o_cpu_wr), 64'(cur.wr));
                end
            end
            tick();
        end
        idle_inputs();
        check("rnd_drained", 64'(q.size() == 0 && mphase == 0), 64'd1);
        tick();
        check("rnd_done_cnt", 64'(o_done_cnt), 64'(exp_done));
        check("rnd_err_cnt", 64'(o_err_cnt), 64'(exp_err));
        check("rnd_busy", 64'(o_busy), 64'd0);
        check("rnd_timeout", 64'(o_timeout), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vt[0] = '{wr: 1'b1, addr: 27'h0000100, bad: -1, beat3: 64'h0000_0000_0001_0003,
                  done: 1, err: 0};
        vt[1] = '{wr: 1'b0, addr: 27'h0000010, bad: 5, beat3: 64'h0000_0000_0000_1003,
                  done: 2, err: CHK};
        vt[2] = '{wr: 1'b1, addr: 27'h7FFFFFF, bad: -1, beat3: 64'h0000_0007_FFFF_FF03,
                  done: 3, err: CHK};
        vt[3] = '{wr: 1'b0, addr: 27'h5A5A5A5, bad: -1, beat3: 64'h0000_0005_A5A5_A503,
                  done: 4, err: CHK};

        idle_inputs();
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_req_ready", 64'(o_req_ready), 64'd1);
        check("reset_cpu_valid", 64'(o_cpu_valid), 64'd0);
        check("reset_wvalid", 64'(o_cpu_wvalid), 64'd0);
        check("reset_busy", 64'(o_busy), 64'd0);
        check("reset_done", 64'(o_done_cnt), 64'd0);
        check("reset_err", 64'(o_err_cnt), 64'd0);
        check("reset_timeout", 64'(o_timeout), 64'd0);

        do_reset();
        for (int i = 0; i < 4; i++) run_vec(vt[i]);

        test_backpressure();
        test_timeout_then_reset();
        test_stray();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
